// File: rtl/dm_port_arbiter.sv
// Two-port arbiter sharing the mmu data-memory port between the LSU (port 0) and a secondary master.
// Define DM_ARB_RR_EN for round-robin with burst limit; otherwise port 0 has fixed priority.
module dm_port_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned BURST_W   = 3
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  input  logic [3:0]  be0_i,
  input  logic [3:0]  be1_i,
  input  logic        sgn0_i,
  input  logic        sgn1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_di_o,
  output logic [3:0]  dm_be_o,
  output logic        is_signed_o,
  input  logic [31:0] dm_do_i
);

  logic       sel0, sel1;
  logic [1:0] rd_pend_q, rd_pend_d;

`ifdef DM_ARB_RR_EN
  localparam logic [BURST_W-1:0] MaxBurst = BURST_W'(MAX_BURST);

  logic               owner_q, owner_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               pick1;

  // Winner under contention. A zero count means the owner has no live burst, so the
  // non-owner goes first (this is what makes port 0 win right after reset).
  always_comb begin
    pick1 = ~owner_q;
    if (burst_cnt_q != '0 && burst_cnt_q < MaxBurst) begin
      pick1 = owner_q;
    end
  end

  always_comb begin
    sel0 = req0_i & (~req1_i | ~pick1);
    sel1 = req1_i & (~req0_i | pick1);
  end

  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = '0;
    if (gnt0_o || gnt1_o) begin
      owner_d = gnt1_o;
      if (gnt1_o == owner_q) begin
        burst_cnt_d = (burst_cnt_q >= MaxBurst) ? burst_cnt_q : burst_cnt_q + BURST_W'(1);
      end else begin
        burst_cnt_d = BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      owner_q     <= 1'b1;
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  logic unused_params;
  assign unused_params = ^{MAX_BURST, BURST_W};

  always_comb begin
    sel0 = req0_i;
    sel1 = req1_i & ~req0_i;
  end
`endif

  // Grants are forced low while reset is asserted.
  always_comb begin
    gnt0_o = resetb & sel0;
    gnt1_o = resetb & sel1;
  end

  always_comb begin
    dm_we_o     = 1'b0;
    dm_addr_o   = '0;
    dm_di_o     = '0;
    dm_be_o     = '0;
    is_signed_o = 1'b0;
    if (gnt0_o) begin
      dm_we_o     = we0_i;
      dm_addr_o   = addr0_i;
      dm_di_o     = wdata0_i;
      dm_be_o     = be0_i;
      is_signed_o = sgn0_i;
    end else if (gnt1_o) begin
      dm_we_o     = we1_i;
      dm_addr_o   = addr1_i;
      dm_di_o     = wdata1_i;
      dm_be_o     = be1_i;
      is_signed_o = sgn1_i;
    end
  end

  // Tracks which port's read the mmu pipeline register returns next cycle.
  always_comb begin
    rd_pend_d = {gnt1_o & ~we1_i, gnt0_o & ~we0_i};
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_pend_q <= 2'b00;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    rvalid0_o = rd_pend_q[0];
    rvalid1_o = rd_pend_q[1];
    rdata_o   = dm_do_i;
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: vector table plus multi-cycle sequences, with a behavioural mmu
// and a read-return scoreboard. Arbitration expectations follow DM_ARB_RR_EN when defined.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        resetb;
  logic        req0, req1, we0, we1, sgn0, sgn1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic        dm_we, is_signed;
  logic [31:0] dm_addr, dm_di;
  logic [3:0]  dm_be;
  logic [31:0] dm_do = 32'h0;

  dm_port_arbiter #(.MAX_BURST(4), .BURST_W(3)) dut (
    .clk(clk), .resetb(resetb),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .be0_i(be0), .be1_i(be1), .sgn0_i(sgn0), .sgn1_i(sgn1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata_o(rdata), .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_di_o(dm_di),
    .dm_be_o(dm_be), .is_signed_o(is_signed), .dm_do_i(dm_do)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r0; logic w0; logic [31:0] a0; logic [31:0] d0; logic [3:0] b0; logic s0;
    logic r1; logic w1; logic [31:0] a1; logic [31:0] d1; logic [3:0] b1; logic s1;
    logic eg0; logic eg1;
  } vec_t;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mmu_mem[logic [29:0]];
  logic [31:0] ref_mem[logic [29:0]];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return {wa[15:0], ~wa[15:0]};
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [3:0] be,
                                          input logic sgn);
    case (be)
      4'b1111: return w;
      4'b1100: return {{16{sgn & w[31]}}, w[31:16]};
      4'b0011: return {{16{sgn & w[15]}}, w[15:0]};
      4'b0001: return {{24{sgn & w[7]}}, w[7:0]};
      4'b0010: return {{24{sgn & w[15]}}, w[15:8]};
      4'b0100: return {{24{sgn & w[23]}}, w[23:16]};
      4'b1000: return {{24{sgn & w[31]}}, w[31:24]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mmu_rd(input logic [29:0] wa);
    return mmu_mem.exists(wa) ? mmu_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  // Behavioural mmu: one-cycle registered read data, lane extraction done here.
  always @(posedge clk) begin
    if (dm_be != 4'b0000) begin
      if (dm_we) mmu_mem[dm_addr[31:2]] = merge(mmu_rd(dm_addr[31:2]), dm_di, dm_be);
      else dm_do <= extract(mmu_rd(dm_addr[31:2]), dm_be, is_signed);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] rv, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic s);
    sb_t e;
    if (w) begin
      ref_mem[a[31:2]] = merge(ref_rd(a[31:2]), d, b);
    end else begin
      e.rv   = rv;
      e.data = extract(ref_rd(a[31:2]), b, s);
      sb.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input vec_t v, input string nm);
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    logic        ew, es;
    logic [1:0]  erv;
    sb_t         e;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0; be0 = v.b0; sgn0 = v.s0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1; be1 = v.b1; sgn1 = v.s1;
    #2;
    check({nm, " gnt0"}, 32'(gnt0), 32'(v.eg0));
    check({nm, " gnt1"}, 32'(gnt1), 32'(v.eg1));
    ea = '0; ed = '0; eb = '0; ew = 1'b0; es = 1'b0;
    if (v.eg0) begin
      ea = v.a0; ed = v.d0; eb = v.b0; ew = v.w0; es = v.s0;
    end else if (v.eg1) begin
      ea = v.a1; ed = v.d1; eb = v.b1; ew = v.w1; es = v.s1;
    end
    check({nm, " dm_we"}, 32'(dm_we), 32'(ew));
    check({nm, " dm_addr"}, dm_addr, ea);
    check({nm, " dm_di"}, dm_di, ed);
    check({nm, " dm_be"}, 32'(dm_be), 32'(eb));
    check({nm, " is_signed"}, 32'(is_signed), 32'(es));
    if (v.eg0) issue(2'b01, v.w0, v.a0, v.d0, v.b0, v.s0);
    else if (v.eg1) issue(2'b10, v.w1, v.a1, v.d1, v.b1, v.s1);
    @(posedge clk);
    #1;
    erv = 2'b00;
    ed  = '0;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      erv = e.rv;
      ed  = e.data;
    end
    check({nm, " rvalid"}, 32'({rvalid1, rvalid0}), 32'(erv));
    if (erv != 2'b00) check({nm, " rdata"}, rdata, ed);
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0; sgn0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0; sgn1 = 1'b0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    resetb = 1'b0;
    sb.delete();
    @(posedge clk);
    #3;
    resetb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t both_rd(input logic eg0, input logic eg1);
    return '{1'b1, 1'b0, 32'h1000_0100, 32'h0, 4'hF, 1'b0,
             1'b1, 1'b0, 32'h1000_0204, 32'h0, 4'hF, 1'b0, eg0, eg1};
  endfunction

  function automatic vec_t only_rd(input logic p1);
    return '{~p1, 1'b0, 32'h1000_0100, 32'h0, 4'hF, 1'b0,
             p1, 1'b0, 32'h1000_0204, 32'h0, 4'hF, 1'b0, ~p1, p1};
  endfunction

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'b1111, 1'b0,
                1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0,
                1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0,
                1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 32'h1000_0013, 32'h0, 4'b1000, 1'b1,
                1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'h8000_0004, 32'h0000_00AA, 4'b1111, 1'b0,
                1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0,
                1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'b0011, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'b1100, 1'b1,
                1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0,
                1'b1, 1'b0, 32'h1000_0024, 32'h0, 4'b0100, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'b1100, 1'b1,
                1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0,
                1'b1, 1'b0, 32'h1000_0028, 32'h0, 4'b0010, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0,
                1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0};

    // Reset state with both ports requesting.
    resetb = 1'b0;
    idle_inputs();
    req0 = 1'b1; be0 = 4'hF; req1 = 1'b1; be1 = 4'hF; we1 = 1'b1;
    #3;
    check("reset gnt0", 32'(gnt0), 32'd0);
    check("reset gnt1", 32'(gnt1), 32'd0);
    check("reset dm_be", 32'(dm_be), 32'd0);
    check("reset dm_we", 32'(dm_we), 32'd0);
    check("reset rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    #2;
    resetb = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) step(tbl[i], $sformatf("vec%0d", i));
    check("lb signed value", ref_rd(30'h0400_0004), 32'hDEAD_BEEF);

    // Port 1 read, then reset before its data returns: the return must be dropped.
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h1000_0030; be1 = 4'hF; sgn1 = 1'b0;
    #2;
    check("midrst gnt1 pre", 32'(gnt1), 32'd1);
    @(posedge clk);
    #1;
    resetb = 1'b0;
    #1;
    check("midrst rvalid1", 32'(rvalid1), 32'd0);
    check("midrst gnt1", 32'(gnt1), 32'd0);
    @(posedge clk);
    #1;
    check("midrst rvalid1 hold", 32'(rvalid1), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h1000_0100; be0 = 4'hF;
    #1;
    resetb = 1'b1;
    step(both_rd(1'b1, 1'b0), "postrst first");

`ifdef DM_ARB_RR_EN
    reset_pulse();
    for (int i = 0; i < 9; i++) begin
      step(both_rd(((i / 4) % 2) == 0, ((i / 4) % 2) == 1), $sformatf("rr%0d", i));
    end

    // Saturated owner with the other port idle, then contention and owner drop at the limit.
    reset_pulse();
    for (int i = 0; i < 6; i++) step(only_rd(1'b0), $sformatf("sat%0d", i));
    step(both_rd(1'b0, 1'b1), "sat switch");
    for (int i = 0; i < 3; i++) step(both_rd(1'b0, 1'b1), $sformatf("p1burst%0d", i));
    step(only_rd(1'b0), "owner drop");
`else
    for (int i = 0; i < 10; i++) step(both_rd(1'b1, 1'b0), $sformatf("fixed%0d", i));
    step(only_rd(1'b1), "fixed release");
`endif

    idle_inputs();
    step(tbl[10], "drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
